// File: rtl/ex_muldiv.sv
// Iterative 32-cycle MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Operands are sign-stripped on entry, iterated unsigned, then sign-corrected on exit.
module ex_muldiv #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] rs_in,
    input  logic [XLEN-1:0] rt_in,
    input  logic            hilo_access,
    input  logic            wr_hi,
    input  logic            wr_lo,
    input  logic [XLEN-1:0] wr_data,
    output logic [XLEN-1:0] hi_out,
    output logic [XLEN-1:0] lo_out,
    output logic            busy,
    output logic            stall,
    output logic            done,
    output logic            div_by_zero
);

    localparam int unsigned CntW = $clog2(XLEN);
    localparam logic [CntW-1:0] LastIter = CntW'(XLEN - 1);

    typedef enum logic [1:0] {StIdle, StRun, StSign} state_e;

    state_e              state_q;
    logic [1:0]          op_q;
    logic [XLEN-1:0]     a_q;
    logic [2*XLEN-1:0]   acc_q;
    logic                neg_q;
    logic                rem_neg_q;
    logic                dbz_q;
    logic [XLEN-1:0]     rs_raw_q;
    logic [CntW-1:0]     cnt_q;
    logic [XLEN-1:0]     hi_q;
    logic [XLEN-1:0]     lo_q;
    logic                busy_q;
    logic                done_q;
    logic                div_by_zero_q;

    logic                rs_neg;
    logic                rt_neg;
    logic [XLEN-1:0]     rs_mag;
    logic [XLEN-1:0]     rt_mag;
    logic [XLEN:0]       mul_sum;
    logic [2*XLEN-1:0]   mul_next;
    logic [XLEN:0]       div_shift;
    logic [XLEN:0]       div_diff;
    logic [2*XLEN-1:0]   div_next;
    logic [2*XLEN-1:0]   prod_res;
    logic [XLEN-1:0]     quot_res;
    logic [XLEN-1:0]     rem_res;

    always_comb begin
        rs_neg = op[0] & rs_in[XLEN-1];
        rt_neg = op[0] & rt_in[XLEN-1];
        rs_mag = rs_neg ? -rs_in : rs_in;
        rt_mag = rt_neg ? -rt_in : rt_in;

        // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, a_q} : '0);
        mul_next = {mul_sum, acc_q[XLEN-1:1]};

        // Divide: acc = {remainder, dividend/quotient}; a borrow in the top bit means restore.
        div_shift = acc_q[2*XLEN-1:XLEN-1];
        div_diff  = div_shift - {1'b0, a_q};
        div_next  = div_diff[XLEN] ? {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                   : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

        prod_res = (neg_q & op_q[0]) ? -acc_q : acc_q;
        quot_res = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem_res  = rem_neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            op_q          <= '0;
            a_q           <= '0;
            acc_q         <= '0;
            neg_q         <= 1'b0;
            rem_neg_q     <= 1'b0;
            dbz_q         <= 1'b0;
            rs_raw_q      <= '0;
            cnt_q         <= '0;
            hi_q          <= '0;
            lo_q          <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            div_by_zero_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        op_q          <= op;
                        a_q           <= op[1] ? rt_mag : rs_mag;
                        acc_q         <= {{XLEN{1'b0}}, (op[1] ? rs_mag : rt_mag)};
                        neg_q         <= rs_neg ^ rt_neg;
                        rem_neg_q     <= rs_neg;
                        dbz_q         <= (rt_in == '0);
                        rs_raw_q      <= rs_in;
                        cnt_q         <= '0;
                        div_by_zero_q <= 1'b0;
                        busy_q        <= 1'b1;
                        state_q       <= StRun;
                    end else begin
                        if (wr_hi) hi_q <= wr_data;
                        if (wr_lo) lo_q <= wr_data;
                    end
                end
                StRun: begin
                    acc_q <= op_q[1] ? div_next : mul_next;
                    cnt_q <= cnt_q + CntW'(1);
                    if (cnt_q == LastIter) state_q <= StSign;
                end
                StSign: begin
                    if (!op_q[1]) begin
                        hi_q <= prod_res[2*XLEN-1:XLEN];
                        lo_q <= prod_res[XLEN-1:0];
                    end else if (dbz_q) begin
                        hi_q          <= rs_raw_q;
                        lo_q          <= '1;
                        div_by_zero_q <= 1'b1;
                    end else begin
                        hi_q <= rem_res;
                        lo_q <= quot_res;
                    end
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign hi_out      = hi_q;
    assign lo_out      = lo_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = div_by_zero_q;
    assign stall       = busy_q & (start | hilo_access);

endmodule

// File: tb/tb_ex_muldiv.sv
// Scoreboard bench for ex_muldiv: expected HI/LO/div_by_zero queued at issue, popped at done.
module tb_ex_muldiv;

    localparam logic [1:0] OpMultu = 2'b00;
    localparam logic [1:0] OpMult  = 2'b01;
    localparam logic [1:0] OpDivu  = 2'b10;
    localparam logic [1:0] OpDiv   = 2'b11;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } res_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] rs_in = '0;
    logic [31:0] rt_in = '0;
    logic        hilo_access = 1'b0;
    logic        wr_hi = 1'b0;
    logic        wr_lo = 1'b0;
    logic [31:0] wr_data = '0;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic        busy;
    logic        stall;
    logic        done;
    logic        div_by_zero;

    res_t sb[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    ex_muldiv #(.XLEN(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op          (op),
        .rs_in       (rs_in),
        .rt_in       (rt_in),
        .hilo_access (hilo_access),
        .wr_hi       (wr_hi),
        .wr_lo       (wr_lo),
        .wr_data     (wr_data),
        .hi_out      (hi_out),
        .lo_out      (lo_out),
        .busy        (busy),
        .stall       (stall),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    function automatic res_t model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        res_t               r;
        logic [63:0]        p;
        logic signed [63:0] sa64;
        logic signed [63:0] sb64;
        int                 sa;
        int                 sb_i;
        r.dbz = 1'b0;
        case (o)
            OpMultu: begin
                p = {32'h0, a} * {32'h0, b};
                r.hi = p[63:32];
                r.lo = p[31:0];
            end
            OpMult: begin
                sa64 = {{32{a[31]}}, a};
                sb64 = {{32{b[31]}}, b};
                p = sa64 * sb64;
                r.hi = p[63:32];
                r.lo = p[31:0];
            end
            OpDivu: begin
                if (b == 32'h0) begin
                    r.hi = a; r.lo = 32'hFFFF_FFFF; r.dbz = 1'b1;
                end else begin
                    r.hi = a % b; r.lo = a / b;
                end
            end
            default: begin
                if (b == 32'h0) begin
                    r.hi = a; r.lo = 32'hFFFF_FFFF; r.dbz = 1'b1;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    r.hi = 32'h0; r.lo = 32'h8000_0000;
                end else begin
                    sa = a; sb_i = b;
                    r.lo = sa / sb_i;
                    r.hi = sa % sb_i;
                end
            end
        endcase
        return r;
    endfunction

    // Drives one start pulse (sampled at the next edge E0) and returns at E0+1.
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input res_t exp);
        start = 1'b1; op = o; rs_in = a; rt_in = b;
        @(posedge clk); #1;
        start = 1'b0; op = 2'($urandom); rs_in = $urandom; rt_in = $urandom;
        sb.push_back(exp);
    endtask

    // Counts busy cycles after E0 and done pulses; bounded so a stuck DUT cannot hang the run.
    task automatic wait_done(output int cycles, output int pulses);
        cycles = 0; pulses = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done) pulses++;
            if (!busy) break;
            cycles++;
        end
        @(negedge clk);
        if (done) pulses++;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++; if (hi_out !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h want 0", hi_out); end
        checks++; if (lo_out !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h want 0", lo_out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz: got %b want 0", div_by_zero); end
        hilo_access = 1'b1; #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall); end
        hilo_access = 1'b0;
    endtask

    task automatic test_multu;
        int cyc, pul;
        res_t exp;
        issue(OpMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, '{32'hFFFF_FFFE, 32'h0000_0001, 1'b0});
        wait_done(cyc, pul);
        checks++; if (cyc != 33) begin errors++; $display("FAIL multu_busy_cycles: got %0d want 33", cyc); end
        checks++; if (pul != 1) begin errors++; $display("FAIL multu_done_pulses: got %0d want 1", pul); end
        exp = sb.pop_front();
        checks++; if (hi_out !== exp.hi) begin errors++; $display("FAIL multu_hi: got %h want %h", hi_out, exp.hi); end
        checks++; if (lo_out !== exp.lo) begin errors++; $display("FAIL multu_lo: got %h want %h", lo_out, exp.lo); end
    endtask

    task automatic test_signed;
        int cyc, pul;
        res_t exp;
        issue(OpMult, 32'hFFFF_FFFD, 32'h5, '{32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0});
        wait_done(cyc, pul);
        exp = sb.pop_front();
        checks++; if (hi_out !== exp.hi || lo_out !== exp.lo) begin
            errors++; $display("FAIL mult_neg: got %h_%h want %h_%h", hi_out, lo_out, exp.hi, exp.lo);
        end
        issue(OpDiv, 32'hFFFF_FFF9, 32'h2, '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0});
        wait_done(cyc, pul);
        exp = sb.pop_front();
        checks++; if (pul != 1) begin errors++; $display("FAIL div_done_pulses: got %0d want 1", pul); end
        checks++; if (hi_out !== exp.hi || lo_out !== exp.lo) begin
            errors++; $display("FAIL div_neg: got %h_%h want %h_%h", hi_out, lo_out, exp.hi, exp.lo);
        end
    endtask

    task automatic test_div_by_zero;
        int cyc, pul;
        res_t exp;
        issue(OpDivu, 32'd100, 32'h0, '{32'h0000_0064, 32'hFFFF_FFFF, 1'b1});
        wait_done(cyc, pul);
        exp = sb.pop_front();
        checks++; if (hi_out !== exp.hi || lo_out !== exp.lo || div_by_zero !== exp.dbz) begin
            errors++; $display("FAIL divu_zero: got %h_%h dbz=%b want %h_%h dbz=%b",
                               hi_out, lo_out, div_by_zero, exp.hi, exp.lo, exp.dbz);
        end
        issue(OpMultu, 32'd5, 32'd5, '{32'h0, 32'd25, 1'b0});
        checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL dbz_clear: got %b want 0", div_by_zero); end
        wait_done(cyc, pul);
        exp = sb.pop_front();
        checks++; if (lo_out !== exp.lo) begin errors++; $display("FAIL multu_after_dbz: got %h want %h", lo_out, exp.lo); end
        issue(OpDiv, 32'hFFFF_FF00, 32'h0, '{32'hFFFF_FF00, 32'hFFFF_FFFF, 1'b1});
        wait_done(cyc, pul);
        exp = sb.pop_front();
        checks++; if (hi_out !== exp.hi || lo_out !== exp.lo || div_by_zero !== exp.dbz) begin
            errors++; $display("FAIL div_zero_signed: got %h_%h dbz=%b want %h_%h dbz=%b",
                               hi_out, lo_out, div_by_zero, exp.hi, exp.lo, exp.dbz);
        end
    endtask

    task automatic test_stall_ignore;
        int cyc, pul;
        res_t exp;
        // HI is 0xFFFFFF00 from the preceding signed divide-by-zero.
        issue(OpMultu, 32'd7, 32'd6, '{32'h0, 32'd42, 1'b0});
        repeat (4) @(posedge clk);
        #1 start = 1'b1; op = OpDivu; rs_in = 32'd9; rt_in = 32'd3;
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL stall_on_start: got %b want 1", stall); end
        @(posedge clk); #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #1 hilo_access = 1'b1; wr_hi = 1'b1; wr_data = 32'hDEAD_BEEF;
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL stall_on_hilo: got %b want 1", stall); end
        @(posedge clk); #1 hilo_access = 1'b0; wr_hi = 1'b0;
        checks++; if (hi_out !== 32'hFFFF_FF00) begin errors++; $display("FAIL hi_hold_busy: got %h want ffffff00", hi_out); end
        wait_done(cyc, pul);
        exp = sb.pop_front();
        checks++; if (hi_out !== exp.hi || lo_out !== exp.lo) begin
            errors++; $display("FAIL stall_result: got %h_%h want %h_%h", hi_out, lo_out, exp.hi, exp.lo);
        end
        repeat (5) @(negedge clk);
        checks++; if (busy !== 1'b0 || lo_out !== 32'd42) begin
            errors++; $display("FAIL ignored_start: got busy=%b lo=%h want busy=0 lo=0000002a", busy, lo_out);
        end
    endtask

    task automatic test_reset_abort;
        int cyc, pul;
        res_t exp;
        @(posedge clk); #1 hilo_access = 1'b1; wr_hi = 1'b1; wr_data = 32'hAAAA_5555;
        @(posedge clk); #1 hilo_access = 1'b0; wr_hi = 1'b0;
        checks++; if (hi_out !== 32'hAAAA_5555) begin errors++; $display("FAIL mthi: got %h want aaaa5555", hi_out); end
        issue(OpMultu, 32'd3, 32'd3, '{32'h0, 32'd9, 1'b0});
        repeat (4) @(posedge clk);
        #1;
        checks++; if (hi_out !== 32'hAAAA_5555 || busy !== 1'b1) begin
            errors++; $display("FAIL mid_op: got hi=%h busy=%b want hi=aaaa5555 busy=1", hi_out, busy);
        end
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        checks++; if (busy !== 1'b0 || hi_out !== 32'h0 || lo_out !== 32'h0 || done !== 1'b0) begin
            errors++; $display("FAIL reset_abort: got busy=%b hi=%h lo=%h done=%b want 0/0/0/0",
                               busy, hi_out, lo_out, done);
        end
        sb.delete();
        pul = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) pul++;
        end
        checks++; if (pul != 0 || lo_out !== 32'h0) begin
            errors++; $display("FAIL no_done_after_abort: got pulses=%0d lo=%h want 0/0", pul, lo_out);
        end
        issue(OpMultu, 32'd3, 32'd3, '{32'h0, 32'd9, 1'b0});
        wait_done(cyc, pul);
        exp = sb.pop_front();
        checks++; if (hi_out !== exp.hi || lo_out !== exp.lo) begin
            errors++; $display("FAIL multu_after_reset: got %h_%h want %h_%h", hi_out, lo_out, exp.hi, exp.lo);
        end
    endtask

    task automatic test_back_to_back;
        int cyc, pul;
        res_t exp;
        logic [1:0]  o;
        logic [31:0] a, b;
        for (int i = 0; i < 12; i++) begin
            case (i)
                0: begin o = OpDiv;  a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                1: begin o = OpDiv;  a = 32'd7;         b = 32'hFFFF_FFFE; end
                2: begin o = OpMult; a = 32'h8000_0000; b = 32'h8000_0000; end
                3: begin o = OpDivu; a = 32'hFFFF_FFFF; b = 32'h10; end
                default: begin
                    o = 2'($urandom);
                    a = $urandom;
                    b = ($urandom_range(0, 7) == 0) ? 32'h0 : ($urandom >> $urandom_range(0, 24));
                end
            endcase
            issue(o, a, b, model(o, a, b));
            wait_done(cyc, pul);
            if (sb.size() == 0) begin
                errors++; checks++;
                $display("FAIL b2b_sb_empty: got 0 entries want 1");
            end else begin
                exp = sb.pop_front();
                checks++; if (pul != 1 || hi_out !== exp.hi || lo_out !== exp.lo || div_by_zero !== exp.dbz) begin
                    errors++;
                    $display("FAIL b2b_%0d op=%0d a=%h b=%h: got %h_%h dbz=%b pulses=%0d want %h_%h dbz=%b",
                             i, o, a, b, hi_out, lo_out, div_by_zero, pul, exp.hi, exp.lo, exp.dbz);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_multu();
        test_signed();
        test_div_by_zero();
        test_stall_ignore();
        test_reset_abort();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
